// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore sequencer for the multicycle CPU datapath with a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             Beq,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired_count
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, BRANCH, JUMP, JAL, IMMEX, IMMWB, ILLEGAL
  } state_t;
  state_t r_state, w_next;
  logic r_imm_sub, w_retire;
  logic [CNT_W-1:0] r_cnt;
  assign state = r_state;
  assign retired_count = r_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_imm_sub <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
      if (r_state == DECODE) r_imm_sub <= opcode == 6'h0E;
    end
  end
  always_comb begin
    w_next = IDLE;
    w_retire = 1'b0;
    PCWrite = 1'b0;
    Beq = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegDst = 2'd0;
    MemToReg = 2'd0;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'd0;
    ALUOp = 3'd0;
    PCSource = 2'd0;
    illegal_op = 1'b0;
    case (r_state)
      IDLE: w_next = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        w_next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'd3;
        case (opcode)
          6'h00: w_next = EXEC;
          6'h23, 6'h2B: w_next = MEMADR;
          6'h04: w_next = BRANCH;
          6'h02: w_next = JUMP;
          6'h03: w_next = JAL;
          6'h08, 6'h0E: w_next = IMMEX;
          default: w_next = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        w_next = opcode == 6'h23 ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD = 1'b1;
        MemRead = 1'b1;
        w_next = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemToReg = 2'd1;
        RegWrite = 1'b1;
        w_retire = 1'b1;
        w_next = FETCH;
      end
      MEMWR: begin
        IorD = 1'b1;
        MemWrite = 1'b1;
        w_retire = mem_ready;
        w_next = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp = 3'd4;
        w_next = ALUWB;
      end
      ALUWB: begin
        RegDst = 2'd1;
        RegWrite = 1'b1;
        w_retire = 1'b1;
        w_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = 3'd1;
        Beq = 1'b1;
        PCSource = 2'd1;
        w_retire = 1'b1;
        w_next = FETCH;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'd2;
        w_retire = 1'b1;
        w_next = FETCH;
      end
      JAL: begin
        PCWrite = 1'b1;
        PCSource = 2'd2;
        RegDst = 2'd2;
        MemToReg = 2'd2;
        RegWrite = 1'b1;
        w_retire = 1'b1;
        w_next = FETCH;
      end
      IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUOp = r_imm_sub ? 3'd3 : 3'd2;
        w_next = IMMWB;
      end
      IMMWB: begin
        RegWrite = 1'b1;
        w_retire = 1'b1;
        w_next = FETCH;
      end
      ILLEGAL: begin
        illegal_op = 1'b1;
        w_next = FETCH;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multicycle variant of the CPU: one shared memory port, one ALU, and an IR/ALUOut/MDR register set.
- Decodes the IR opcode and steps the datapath through fetch/decode/execute/memory/writeback states, stalling on a memory-ready handshake.
- Provides the same instruction set as the single-cycle Control unit, with identical RegDst/MemToReg/ALUOp encodings, plus a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
opcode  input  6  IR[31:26], stable from the cycle after FETCH completes
mem_ready  input  1  memory completes the access this cycle
PCWrite  output  1  unconditional PC load
Beq  output  1  PC load qualified by ALU zero (PCWriteCond)
IorD  output  1  0=PC, 1=ALUOut drives memory address
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load IR from memory data
RegDst  output  2  0=rt, 1=rd, 2=$31
MemToReg  output  2  0=ALUOut, 1=MDR, 2=PC
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=rs
ALUSrcB  output  2  0=rt, 1=const 4, 2=signext imm, 3=signext imm<<2
ALUOp  output  3  0=add, 1=sub(beq), 2=addi, 3=subi, 4=R-type funct
PCSource  output  2  0=ALU result, 1=ALUOut, 2=jump address
illegal_op  output  1  one-cycle pulse on unknown opcode
state  output  4  current state encoding, for debug
retired_count  output  CNT_W  instructions completed

Behaviour:
- State register: 4 bits. All outputs are decoded from state (Moore), except the mem_ready qualification noted below. Any output not listed for a state is 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, JAL=11, IMMEX=12, IMMWB=13, ILLEGAL=14. Encoding 15 is unused and goes to IDLE.
- Reset: at a clk edge with reset=1, state<=IDLE, retired_count<=0, imm_sub<=0. In IDLE all outputs are 0. IDLE always goes to FETCH on the next edge. Reset overrides every transition, including a MEMWR wait.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0. IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0. Latches imm_sub<=(opcode==0x0E). Next state by opcode:
  - 0x00 -> EXEC
  - 0x23 or 0x2B -> MEMADR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - 0x08 or 0x0E (subi) -> IMMEX
  - any other opcode -> ILLEGAL
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Goes to MEMRD if opcode==0x23, else MEMWR.
- MEMRD: IorD=1, MemRead=1. Held until mem_ready, then MEMWB.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1, held asserted for the whole wait. Goes to FETCH when mem_ready.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=4 -> ALUWB.
- ALUWB: RegDst=1, MemToReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, Beq=1, PCSource=1 -> FETCH.
- JUMP: PCWrite=1, PCSource=2 -> FETCH.
- JAL: PCWrite=1, PCSource=2, RegDst=2, MemToReg=2, RegWrite=1 -> FETCH. The PC written to $31 is the already-incremented PC+4.
- IMMEX: ALUSrcA=1, ALUSrcB=2, ALUOp = imm_sub ? 3 : 2 -> IMMWB.
- IMMWB: RegDst=0, MemToReg=0, RegWrite=1 -> FETCH.
- ILLEGAL: illegal_op=1 for one cycle -> FETCH. No register or memory write occurs.
- Latency with mem_ready held at 1: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, jal 3, addi 4, subi 4, illegal 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds 1 cycle.
- retired_count:
  - Increments by 1 on the edge leaving MEMWB, ALUWB, BRANCH, JUMP, JAL or IMMWB.
  - Also increments leaving MEMWR, only on the edge where mem_ready=1.
  - Does not increment for ILLEGAL.
  - Wraps modulo 2^CNT_W with no flag.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.

Test Plan:
- Reset, then R-type: reset=1 for 2 cycles, opcode=0x00, mem_ready=1 -> state sequence 0,1,2,7,8,1. In state 8: RegWrite=1, RegDst=1. retired_count=1 after ALUWB.
- lw with wait states: opcode=0x23, mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD -> IRWrite/PCWrite pulse exactly once. State 4 is held 4 cycles with IorD=1, MemRead=1. MEMWB gives MemToReg=1. Total 10 cycles; count +1.
- sw then reset mid-wait: opcode=0x2B, mem_ready=0, reset asserted in MEMWR -> MemWrite=1 up to the reset edge, then 0. State=0 and retired_count=0 after the edge.
- jal and j: opcode=0x03 -> state 11 with PCWrite=1, PCSource=2, RegDst=2, MemToReg=2, RegWrite=1. opcode=0x02 -> state 10 with RegWrite=0. Each takes 3 cycles.
- addi vs subi: opcode=0x08 -> IMMEX ALUOp=2. opcode=0x0E -> IMMEX ALUOp=3. Both then go to IMMWB with RegDst=0, RegWrite=1.
- Illegal and counter wrap: opcode=0x3F -> illegal_op=1 for exactly one cycle and count unchanged. With CNT_W=2, run 5 beq instructions -> retired_count ends at 1.
